imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: receives a framed byte stream (UART RX or debug link) and writes 32-bit instruction words into the imem write port.
- Holds the core in reset until a valid image is loaded.
- Sits between the byte-stream source and imem/core reset; imem keeps its combinational read port unchanged.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/loader_timeout.sv | 33 +++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: geometry, loader framing constants
// and the loader state encoding.
package imem_pkg;

    localparam int          IMEM_DEPTH_WORDS   = 16384;
    localparam int          IMEM_AW            = 14;
    localparam logic [31:0] NOP_INSN           = 32'h0000_0013;
    localparam logic [7:0]  LOADER_SYNC        = 8'hA5;
    localparam int          LOADER_TIMEOUT_CYC = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    // A frame length is usable when it names at least one word and fits in imem.
    function automatic logic len_valid(input logic [15:0] len, input int depth);
        return (len != 16'd0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts cycles without an accepted byte and flags the
// cycle in which the limit is reached.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // Expiry is combinational so the FSM can react on the very edge that
    // completes the TIMEOUT_CYC-th idle cycle.
    assign expired = enable && !clear && (count == CW'(TIMEOUT_CYC - 1));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // always_ff samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words into imem and
// holds the core in reset until a complete, checksummed image has arrived.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int          AW          = IMEM_AW,
    parameter logic [7:0]  SYNC_BYTE   = LOADER_SYNC,
    parameter int          TIMEOUT_CYC = LOADER_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    loader_state_t state;

    logic [7:0]  len_lo;
    logic [AW:0] len_q;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;

    logic        accept;
    logic        in_frame;
    logic        expired;
    logic [15:0] len_full;
    logic [AW:0] next_count;

    // The only stall is the write cycle, which lets each assembled word reach
    // imem without a skid buffer.
    assign in_ready   = ~mem_we;
    assign accept     = in_valid && in_ready;
    assign in_frame   = (state == LEN0) || (state == LEN1) ||
                        (state == DATA) || (state == CSUM);
    assign len_full   = {in_data, len_lo};
    assign next_count = words_loaded + 1'b1;

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len_q        <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
        end else begin
            load_done <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    // A finished image releases the core one cycle after load_done.
                    if (state == DONE) core_hold <= 1'b0;
                    if (accept && in_data == SYNC_BYTE) begin
                        state        <= LEN0;
                        core_hold    <= 1'b1;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        mem_waddr    <= '0;
                        csum         <= '0;
                    end
                end

                LEN0: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN1;
                    end else if (expired) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end

                LEN1: begin
                    if (accept) begin
                        if (len_valid(len_full, DEPTH_WORDS)) begin
                            len_q    <= (AW+1)'(len_full);
                            byte_idx <= '0;
                            state    <= DATA;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end else if (expired) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end

                DATA: begin
                    if (mem_we) begin
                        // Write cycle: no byte can be accepted, so only bookkeeping.
                        mem_we       <= 1'b0;
                        words_loaded <= next_count;
                        if (next_count == len_q) state <= CSUM;
                        else                     mem_waddr <= mem_waddr + 1'b1;
                    end else if (accept) begin
                        csum     <= csum + in_data;
                        byte_idx <= byte_idx + 1'b1;
                        case (byte_idx)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {in_data, asm_q};
                            end
                        endcase
                    end else if (expired) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end

                CSUM: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end else if (expired) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end

                ERR: begin
                    core_hold <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: frames are built from the framing rules
// and the observed imem writes and status flags are compared with a model.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = IMEM_DEPTH_WORDS;
    localparam int AW    = IMEM_AW;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    imem_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [31:0] fw[$];
    int          done_cnt = 0;
    int          last_hs  = -10;

    // Observer: sampled mid-cycle, so a handshake seen here happens at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            wr_t e;
            check("in_ready", in_ready, !mem_we);
            if (mem_we) begin
                check("wr_latency", cyc - last_hs, 1);
                check("waddr_range", mem_waddr < DEPTH, 1);
                e.addr = int'(mem_waddr);
                e.data = mem_wdata;
                got_q.push_back(e);
            end
            if (load_done) done_cnt++;
            if (in_valid && in_ready) last_hs = cyc;
        end
    end

    // Entered and left at posedge+1; gap < 0 picks a random idle gap.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  g;
        bit  ok;
        g  = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        ok = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("hs_bound", 0, 1);
    endtask

    task automatic send_frame(input int len_field, input bit bad_csum, input int gap);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        logic [15:0] lf;
        bit          len_ok;
        bit          good;
        wr_t         e;
        sum = 8'h00;
        lf  = 16'(len_field);
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        len_ok = (len_field >= 1) && (len_field <= DEPTH);
        good   = len_ok && !bad_csum;
        send_byte(8'hA5, gap);
        send_byte(lf[7:0], gap);
        send_byte(lf[15:8], gap);
        if (len_ok) begin
            for (int i = 0; i < fw.size(); i++) begin
                w = fw[i];
                for (int k = 0; k < 4; k++) begin
                    b   = w[8*k +: 8];
                    sum = sum + b;
                    send_byte(b, gap);
                end
                e.addr = i;
                e.data = w;
                exp_q.push_back(e);
            end
            send_byte(bad_csum ? sum + 8'd1 : sum, gap);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("wr_addr", got_q[i].addr, exp_q[i].addr);
            check("wr_data", got_q[i].data, exp_q[i].data);
        end
        check("done_pulses", done_cnt, good ? 1 : 0);
        check("load_done_low", load_done, 0);
        check("load_err", load_err, !good);
        check("core_hold", core_hold, !good);
        check("words_loaded", words_loaded, len_ok ? fw.size() : 0);
    endtask

    task automatic fill_random(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_waddr"}, mem_waddr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_core_hold"}, core_hold, 1);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Reference frame A5 01 00 13 05 00 00 18.
        fw.delete();
        fw.push_back(32'h0000_0513);
        send_frame(1, 1'b0, 0);

        // Two words with in_valid toggling.
        fill_random(2);
        send_frame(2, 1'b0, 1);

        // Same single-word frame with checksum 19.
        fw.delete();
        fw.push_back(32'h0000_0513);
        send_frame(1, 1'b1, 0);

        // Illegal lengths.
        fw.delete();
        send_frame(0, 1'b0, 0);
        send_frame(DEPTH + 1, 1'b0, 0);

        // Stall after the second data byte.
        got_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_before", load_err, 0);
        @(posedge clk);
        #1;
        check("to_at", load_err, 1);
        check("to_hold", core_hold, 1);
        check("to_no_write", got_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        fill_random(2);
        send_frame(2, 1'b0, -1);

        // Reset in the middle of the second word.
        fill_random(2);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_words", words_loaded, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        fill_random(3);
        send_frame(3, 1'b0, -1);

        // Random frames, occasionally corrupted, restarting from DONE or IDLE.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_random(n);
            send_frame(n, $urandom_range(0, 3) == 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
